// File: rtl/cdr_link_pkg.sv
// rtl/cdr_link_pkg.sv - shared types and constants for the CDR link controller
package cdr_link_pkg;

  typedef enum logic [1:0] {RST_CDR, HUNT, VERIFY, LOCKED} link_state_t;

  localparam int          DEF_SYNC_W    = 16;
  localparam logic [15:0] DEF_SYNC_WORD = 16'hA55A;

  function automatic int frame_bits(input int sync_w, input int frame_bytes);
    return sync_w + 8 * frame_bytes;
  endfunction

endpackage

// File: rtl/sync_word_detector.sv
// rtl/sync_word_detector.sv - sliding sync-word window over the recovered bitstream
module sync_word_detector
  import cdr_link_pkg::*;
#(
  parameter int                SYNC_W    = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_WORD = DEF_SYNC_WORD
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din,
  input  logic clear,
  output logic match
);

  // Only SYNC_W-1 bits of history are kept; the current bit completes the window.
  logic [SYNC_W-2:0] history;
  logic [SYNC_W-1:0] window;

  assign window = {history, din};
  assign match  = en && (window == SYNC_WORD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      history <= '0;
    else if (clear)
      history <= '0;
    else if (en)
      history <= window[SYNC_W-2:0];
  end

endmodule

// File: rtl/cdr_link_controller.sv
// rtl/cdr_link_controller.sv - CDR reset sequencing, sync hunt/verify and MSB-first byte framing
module cdr_link_controller
  import cdr_link_pkg::*;
#(
  parameter int                SYNC_W         = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_WORD      = DEF_SYNC_WORD,
  parameter int                FRAME_BYTES    = 4,
  parameter int                VERIFY_COUNT   = 2,
  parameter int                MISS_LIMIT     = 3,
  parameter int                CDR_RST_CYCLES = 16,
  parameter int                HUNT_TIMEOUT   = 4096
) (
  input  logic       clk_x8,
  input  logic       rst,
  input  logic       cdr_d,
  input  logic       cdr_d_valid,
  input  logic       force_resync,
  output logic       cdr_rst,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_start,
  output logic       locked,
  output logic       lock_lost
);

  localparam int FRAME_BITS   = frame_bits(SYNC_W, FRAME_BYTES);
  localparam int PAYLOAD_BITS = 8 * FRAME_BYTES;
  localparam int BIT_W        = $clog2(FRAME_BITS);
  localparam int CYC_MAX      = (HUNT_TIMEOUT > CDR_RST_CYCLES) ? HUNT_TIMEOUT : CDR_RST_CYCLES;
  localparam int CNT_W        = $clog2(CYC_MAX + 1);
  localparam int VC_W         = $clog2(VERIFY_COUNT + 1);
  localparam int MISS_W       = $clog2(MISS_LIMIT + 1);

  link_state_t       state;
  logic [CNT_W-1:0]  cyc_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [VC_W-1:0]   verify_cnt;
  logic [MISS_W-1:0] miss_cnt;
  logic [6:0]        byte_sr;

  logic       bit_en, match, at_boundary, in_payload, byte_done;
  logic [7:0] next_byte;

  assign bit_en      = cdr_d_valid && (state != RST_CDR);
  assign at_boundary = bit_en && (bit_cnt == BIT_W'(FRAME_BITS - 1));
  assign in_payload  = bit_cnt < BIT_W'(PAYLOAD_BITS);
  assign byte_done   = bit_en && (state == LOCKED) && in_payload && (bit_cnt[2:0] == 3'd7);
  assign next_byte   = {byte_sr, cdr_d};

  sync_word_detector #(
    .SYNC_W   (SYNC_W),
    .SYNC_WORD(SYNC_WORD)
  ) u_detector (
    .clk  (clk_x8),
    .rst  (rst),
    .en   (bit_en),
    .din  (cdr_d),
    .clear(state == RST_CDR),
    .match(match)
  );

  always_ff @(posedge clk_x8 or posedge rst) begin
    if (rst) begin
      state       <= RST_CDR;
      cyc_cnt     <= '0;
      bit_cnt     <= '0;
      verify_cnt  <= '0;
      miss_cnt    <= '0;
      byte_sr     <= '0;
      cdr_rst     <= 1'b1;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      frame_start <= 1'b0;
      lock_lost   <= 1'b0;
      if (force_resync) begin
        state     <= RST_CDR;
        cyc_cnt   <= '0;
        cdr_rst   <= 1'b1;
        locked    <= 1'b0;
        lock_lost <= (state == LOCKED);
      end else begin
        case (state)
          RST_CDR: begin
            if (cyc_cnt == CNT_W'(CDR_RST_CYCLES - 1)) begin
              state   <= HUNT;
              cyc_cnt <= '0;
              cdr_rst <= 1'b0;
            end else begin
              cyc_cnt <= cyc_cnt + 1'b1;
            end
          end
          HUNT: begin
            if (match) begin
              state      <= VERIFY;
              bit_cnt    <= '0;
              verify_cnt <= VC_W'(1);
            end else if (cyc_cnt == CNT_W'(HUNT_TIMEOUT - 1)) begin
              state   <= RST_CDR;
              cyc_cnt <= '0;
              cdr_rst <= 1'b1;
            end else begin
              cyc_cnt <= cyc_cnt + 1'b1;
            end
          end
          VERIFY: begin
            if (at_boundary) begin
              bit_cnt <= '0;
              if (!match) begin
                state   <= HUNT;
                cyc_cnt <= '0;
              end else if (verify_cnt == VC_W'(VERIFY_COUNT - 1)) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end else begin
                verify_cnt <= verify_cnt + 1'b1;
              end
            end else if (bit_en) begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          LOCKED: begin
            if (at_boundary) begin
              bit_cnt <= '0;
              if (match) begin
                miss_cnt <= '0;
              end else if (miss_cnt == MISS_W'(MISS_LIMIT - 1)) begin
                state     <= RST_CDR;
                cyc_cnt   <= '0;
                cdr_rst   <= 1'b1;
                locked    <= 1'b0;
                lock_lost <= 1'b1;
                miss_cnt  <= '0;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end else if (bit_en) begin
              bit_cnt <= bit_cnt + 1'b1;
              if (in_payload) byte_sr <= next_byte[6:0];
              if (byte_done) begin
                data_out    <= next_byte;
                data_valid  <= 1'b1;
                frame_start <= (bit_cnt == BIT_W'(7));
              end
            end
          end
          default: state <= RST_CDR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cdr_link_controller.sv
// tb/tb_cdr_link_controller.sv - scoreboard bench for cdr_link_controller
module tb_cdr_link_controller;
  import cdr_link_pkg::*;

  logic       clk_x8 = 1'b0;
  logic       rst, cdr_d, cdr_d_valid, force_resync;
  logic       cdr_rst, data_valid, frame_start, locked, lock_lost;
  logic [7:0] data_out;

  cdr_link_controller dut (
    .clk_x8      (clk_x8),
    .rst         (rst),
    .cdr_d       (cdr_d),
    .cdr_d_valid (cdr_d_valid),
    .force_resync(force_resync),
    .cdr_rst     (cdr_rst),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_start (frame_start),
    .locked      (locked),
    .lock_lost   (lock_lost)
  );

  always #5 clk_x8 = ~clk_x8;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] data;
    logic       fs;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always @(posedge clk_x8) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk_x8) begin
    #2;
    if (!rst && data_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_data_valid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("data_out", data_out, mon_e.data);
        check("frame_start", frame_start, mon_e.fs);
        check("data_latency", cyc, mon_e.cyc);
      end
    end
  end

  task automatic send_bit(input logic b, input logic fr = 1'b0);
    repeat (7) begin
      @(posedge clk_x8);
      #1;
    end
    cdr_d        = b;
    cdr_d_valid  = 1'b1;
    force_resync = fr;
    @(posedge clk_x8);
    #1;
    cdr_d_valid  = 1'b0;
    force_resync = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] bt, input bit expect_out, input logic fs);
    exp_t e;
    for (int i = 7; i >= 0; i--) send_bit(bt[i]);
    if (expect_out) begin
      e.data = bt;
      e.fs   = fs;
      e.cyc  = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_word16(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_frame(input logic [31:0] pl, input logic [15:0] sync, input bit expect_out);
    for (int k = 3; k >= 0; k--) send_byte(pl[k*8 +: 8], expect_out, k == 3);
    send_word16(sync);
  endtask

  task automatic wait_release(output int n);
    n = 0;
    while (cdr_rst && n < 100) begin
      @(posedge clk_x8);
      #1;
      n++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          n, t;
    logic [15:0] sr;
    logic        b;
    logic [15:0] sw;

    rst = 1'b1; cdr_d = 1'b0; cdr_d_valid = 1'b0; force_resync = 1'b0;
    repeat (3) @(posedge clk_x8);
    #1;
    check("reset_cdr_rst", cdr_rst, 1);
    check("reset_locked", locked, 0);
    check("reset_data_valid", data_valid, 0);
    check("reset_state", dut.state, RST_CDR);
    rst = 1'b0;
    wait_release(n);
    check("rst_cdr_len", n, 16);
    check("hunt_after_rst", dut.state, HUNT);
    check("not_locked_hunt", locked, 0);

    // Acquire lock and receive one frame.
    send_word16(16'hA55A);
    check("verify_not_locked", locked, 0);
    send_frame(32'h01020304, 16'hA55A, 1'b0);
    check("locked_rise", locked, 1);
    send_frame(32'h01020304, 16'hA55A, 1'b1);
    check("locked_hold", locked, 1);

    // Three consecutive misses drop lock.
    send_frame(32'h11121314, 16'h0000, 1'b1);
    check("miss1_locked", locked, 1);
    send_frame(32'h21222324, 16'h0000, 1'b1);
    check("miss2_locked", locked, 1);
    check("miss2_lock_lost", lock_lost, 0);
    send_frame(32'h31323334, 16'h0000, 1'b1);
    check("miss3_lock_lost", lock_lost, 1);
    check("miss3_cdr_rst", cdr_rst, 1);
    check("miss3_locked", locked, 0);
    @(posedge clk_x8);
    #1;
    check("lock_lost_one_shot", lock_lost, 0);
    wait_release(n);
    check("rst_cdr_len_miss", n + 1, 16);

    // Relock, then two misses followed by a good sync keep lock.
    send_word16(16'hA55A);
    send_frame(32'h01020304, 16'hA55A, 1'b0);
    check("relock", locked, 1);
    send_frame(32'h41424344, 16'h0000, 1'b1);
    send_frame(32'h51525354, 16'h0000, 1'b1);
    send_frame(32'h61626364, 16'hA55A, 1'b1);
    check("two_miss_hold", locked, 1);
    send_frame(32'h71727374, 16'h0000, 1'b1);
    check("miss_cnt_cleared", locked, 1);

    // force_resync on the last bit of byte 2.
    send_byte(8'h81, 1'b1, 1'b1);
    send_byte(8'h82, 1'b1, 1'b0);
    sw = 16'h0083;
    for (int i = 7; i >= 1; i--) send_bit(sw[i]);
    send_bit(sw[0], 1'b1);
    check("force_data_valid", data_valid, 0);
    check("force_lock_lost", lock_lost, 1);
    check("force_cdr_rst", cdr_rst, 1);
    check("force_locked", locked, 0);
    wait_release(n);
    check("rst_cdr_len_force", n, 16);

    // Hunt timeout with sync-free random bits.
    sr = '0;
    t  = 0;
    while (!cdr_rst && t < 5000) begin
      if (t % 8 == 0) begin
        b = 1'($urandom_range(0, 1));
        if ({sr[14:0], b} == 16'hA55A) b = ~b;
        sr          = {sr[14:0], b};
        cdr_d       = b;
        cdr_d_valid = 1'b1;
      end else begin
        cdr_d_valid = 1'b0;
      end
      @(posedge clk_x8);
      #1;
      t++;
    end
    cdr_d_valid = 1'b0;
    check("hunt_timeout_cycles", t, 4096);
    wait_release(n);

    // False sync followed by a misaligned one.
    send_word16(16'hA55A);
    check("false_sync_verify", dut.state, VERIFY);
    for (int i = 0; i < 33; i++) send_bit(1'b0);
    sw = 16'hA55A;
    for (int i = 15; i >= 1; i--) send_bit(sw[i]);
    check("misaligned_to_hunt", dut.state, HUNT);
    check("misaligned_locked", locked, 0);
    send_bit(sw[0]);
    check("rehunt_match", dut.state, VERIFY);

    // Lock from here, then async reset mid-byte.
    send_frame(32'h00000000, 16'hA55A, 1'b0);
    check("lock_before_rst", locked, 1);
    send_byte(8'h9C, 1'b1, 1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    #3;
    rst = 1'b1;
    #1;
    check("async_cdr_rst", cdr_rst, 1);
    check("async_locked", locked, 0);
    check("async_data_out", data_out, 0);
    check("async_data_valid", data_valid, 0);
    check("async_frame_start", frame_start, 0);
    check("async_lock_lost", lock_lost, 0);
    repeat (2) @(posedge clk_x8);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk_x8);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdr_link_controller.md
Name: cdr_link_controller

Overview:
Sequences the clock_data_recovery block and frames its recovered bitstream. Consumes d_out/d_out_valid from the CDR and holds the CDR in reset at startup and after loss of lock. Hunts for and verifies a sync word, then deserialises payload bytes MSB-first. Sits directly after the CDR in the clk_x8 domain, feeding the packet layer.

Parameters:
SYNC_W, 16, sync word width in bits
SYNC_WORD, 16'hA55A, frame delimiter, transmitted MSB first
FRAME_BYTES, 4, payload bytes between sync words (frame = SYNC_W + 8*FRAME_BYTES bits)
VERIFY_COUNT, 2, consecutive correctly-spaced sync words required before LOCKED
MISS_LIMIT, 3, consecutive missed sync words in LOCKED before CDR reset
CDR_RST_CYCLES, 16, clk_x8 cycles cdr_rst is held high
HUNT_TIMEOUT, 4096, clk_x8 cycles in HUNT without a sync match before CDR reset

Ports:
clk_x8  in  1  sole clock (8x bit rate)
rst  in  1  asynchronous, active-high reset
cdr_d  in  1  recovered bit (CDR d_out)
cdr_d_valid  in  1  one-cycle strobe, one per recovered bit (CDR d_out_valid)
force_resync  in  1  request immediate CDR reset and re-hunt
cdr_rst  out  1  reset to CDR, active high
data_out  out  8  payload byte
data_valid  out  1  one-cycle strobe, data_out valid
frame_start  out  1  coincides with data_valid of first byte of each frame
locked  out  1  high while in LOCKED
lock_lost  out  1  one-cycle pulse on LOCKED -> RST_CDR

Behaviour:
- Reset (async): state RST_CDR, cycle counter 0, shift reg 0, cdr_rst=1, data_out=0, data_valid=0, frame_start=0, locked=0, lock_lost=0.
- All bit-level state (shift reg, bit counter) advances only on cycles with cdr_d_valid=1; in RST_CDR, cdr_d_valid is ignored.
- Shift reg: SYNC_W bits, shifts cdr_d in at LSB. Match = shift reg after including the current bit == SYNC_WORD.
- States:
  - RST_CDR: cdr_rst=1; counts CDR_RST_CYCLES clk_x8 cycles, then HUNT with shift reg cleared.
  - HUNT: match -> VERIFY, bit counter=0, verify count=1. HUNT_TIMEOUT cycles without match -> RST_CDR.
  - VERIFY: counts 8*FRAME_BYTES + SYNC_W bits. At the boundary bit, a match increments verify count, and reaching VERIFY_COUNT -> LOCKED with bit counter=0. A mismatch -> HUNT. No data output.
  - LOCKED: locked=1. First 8*FRAME_BYTES bits are payload, then SYNC_W sync bits.
    - Sync match at boundary: miss counter cleared.
    - Mismatch: miss counter +1; framing continues on the expected boundary.
    - Miss counter reaching MISS_LIMIT -> RST_CDR with lock_lost pulse.
- Data path: a byte completes on the 8th payload bit strobe. data_out/data_valid are registered and appear the clk_x8 cycle after that strobe. frame_start=1 with byte 0 only.
- Latency: last bit of byte at cdr_d_valid cycle N -> data_valid at N+1.
- Priority (highest first): rst, force_resync, boundary evaluation, timeout.
  - force_resync in any state -> RST_CDR next cycle, counter restarted. lock_lost pulses only if leaving LOCKED.
  - force_resync during RST_CDR restarts its counter.
  - A byte completing in the same cycle as force_resync is discarded (no data_valid).
- Counters saturate and never wrap. Bit counter width is clog2(SYNC_W + 8*FRAME_BYTES). Timeout counter width is clog2(HUNT_TIMEOUT+1).
- Sync words straddling a false match in HUNT are resolved by VERIFY: a wrong alignment fails and returns to HUNT.

Decomposition:
- Package cdr_link_pkg: state enum (RST_CDR, HUNT, VERIFY, LOCKED), default SYNC_WORD/SYNC_W, frame bit-count constant function.
- Sub-module sync_word_detector: shift register plus comparator, enable=cdr_d_valid, clear input, match output. FSM, counters and byte assembly remain in the top module.

Test Plan:
- Reset release, cdr_d_valid every 8 cycles: cdr_rst high for exactly 16 cycles after rst drops, then state HUNT, locked=0.
- Send A55A + 4 bytes 01,02,03,04 + A55A + same payload + A55A: locked rises at the second post-hunt sync. Next frame yields data_valid with 01,02,03,04, frame_start only on 01, each strobe one cycle after that byte's 8th bit strobe.
- Locked, corrupt 3 consecutive sync words to 0000: locked stays high through misses 1-2. On the 3rd, lock_lost pulses once and cdr_rst rises next cycle for 16 cycles. Repeat with 2 corruptions then a good sync: lock is held.
- Random bits without A55A for 4096 cycles after HUNT entry: cdr_rst reasserted. A false single A55A followed by a misaligned second sync: VERIFY -> HUNT, no data_valid.
- force_resync asserted in the same cycle as the 8th bit of byte 2 while locked: no data_valid for that byte, lock_lost=1, cdr_rst next cycle.
- Async rst asserted mid-byte while LOCKED: all outputs zero immediately (no clock edge needed), cdr_rst=1.
